// File: rtl/jtag_led_ctrl.sv
// jtag_led_ctrl: captures JTAG command words via a synchronised toggle and drives static/blink/dim/off LEDs
module jtag_led_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV   = 25000000,
    parameter int WORD_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] jtag_word,
    input  logic              jtag_toggle,
    output logic [3:0]        led,
    output logic              word_valid,
    output logic [7:0]        cmd_count
);
    localparam int PW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   take;
    logic [9:0]             cmd;
    logic [PW-1:0]          prescaler;
    logic                   blink_phase;
    logic [3:0]             pwm_cnt;
    logic                   on;
    logic                   unused_word;
    assign unused_word = ^jtag_word;
    // Detect a toggle flip after it has crossed into the clk domain; also decode the lamp state
    always_comb begin
        take = sync[SYNC_STAGES-1] ^ prev;
        on   = cmd[5:4] == 2'b00 ? 1'b1 :
               cmd[5:4] == 2'b01 ? blink_phase :
               cmd[5:4] == 2'b10 ? (pwm_cnt < cmd[9:6]) : 1'b0;
    end
    // Toggle synchroniser, edge detect and command capture; jtag_word is only sampled on take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= '0;
            prev       <= 1'b0;
            cmd        <= '0;
            word_valid <= 1'b0;
            cmd_count  <= '0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], jtag_toggle};
            prev       <= sync[SYNC_STAGES-1];
            word_valid <= take;
            if (take) begin
                cmd       <= jtag_word[9:0];
                cmd_count <= cmd_count + 8'd1;
            end
        end
    end
    // Blink prescaler; a capture restarts the period lit and overrides a coincident wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
        end else if (take) begin
            prescaler   <= '0;
            blink_phase <= 1'b1;
        end else if (prescaler == PRE_LAST) begin
            prescaler   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end
    // Free-running PWM counter, independent of captures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end
    // Registered active-low LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= 4'hF;
        else        led <= ~(cmd[3:0] & {4{on}});
    end
endmodule

// File: doc/jtag_led_ctrl.md
Name: jtag_led_ctrl

Overview:
- System-clock-side consumer of the JTAG user data register.
- Receives a quasi-static command word and a toggle flag from the TCK/DRCK domain, and synchronises the toggle.
- Captures the word on each toggle edge and decodes it into LED drive: static, blink, PWM dim or off.
- Sits between the BSCANE2 shift/update stage and the board LED pins.

Parameters:
- SYNC_STAGES, 2, flops in the toggle synchroniser chain; legal range 2..4.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.
- WORD_W, 10, width of jtag_word; must be >= 10; bits above [9] are ignored.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- jtag_word  in  WORD_W  command word from the JTAG domain; held stable from before a toggle flip until the next flip.
- jtag_toggle  in  1  inverts once per JTAG UPDATE; asynchronous to clk.
- led  out  4  LED drive, active-low (0 = lit).
- word_valid  out  1  one-cycle pulse when a new word is captured.
- cmd_count  out  8  number of captured commands, wraps modulo 256.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync chain, edge-detect register, command register, prescaler, blink phase and PWM counter all clear to 0.
  - led=4'hF, word_valid=0, cmd_count=0.
- Synchroniser:
  - jtag_toggle passes through SYNC_STAGES flops; the last stage is compared with a prev register.
  - take = sync_last XOR prev. The block never samples jtag_word directly except on take.
- Latency, with sync[0] sampling a flip at edge 1:
  - sync_last changes at edge SYNC_STAGES.
  - The command register loads jtag_word[9:0] at edge SYNC_STAGES+1; word_valid is high for exactly the following cycle; cmd_count increments at the same edge.
  - led reflects the new command from edge SYNC_STAGES+2.
- Command decode: cmd[3:0]=mask, cmd[5:4]=mode, cmd[9:6]=duty.
  - mode 00 static: on=1.
  - mode 01 blink: on=blink_phase.
  - mode 10 dim: on=(pwm_cnt < duty).
  - mode 11 off: on=0.
  - led[i] = !(mask[i] & on), registered.
- Blink:
  - The prescaler counts 0..BLINK_DIV-1 and wraps; blink_phase inverts on wrap.
  - A capture clears the prescaler to 0 and sets blink_phase=1, so a new blink command starts lit.
- PWM:
  - 4-bit free-running pwm_cnt, never reset by captures.
  - duty=0 gives always off; duty=15 gives lit 15 of 16 cycles.
- Upstream rate contract: upstream guarantees >= SYNC_STAGES+3 clk cycles between toggle flips. Under that contract every flip yields exactly one capture. Faster flips may be merged; no other corruption is permitted.
- Reset release with jtag_toggle=1: sync_last becomes 1 while prev=0. This produces exactly one capture of the current jtag_word, SYNC_STAGES+1 edges after release. This is required behaviour, so the LEDs resume the host's last command.
- Reset asserted mid-synchronisation: the pending flip is discarded, except for the release rule above.
- cmd_count: 255 + capture -> 0, with no saturation.
- Simultaneous capture and prescaler wrap: the capture wins. Prescaler=0, phase=1.

Test Plan:
- Reset check: hold rst_n=0 with jtag_toggle=0 -> led=4'hF, word_valid=0, cmd_count=0. Release and run 100 cycles -> values unchanged.
- Static capture (SYNC_STAGES=2): jtag_word=10'b00_0000_0101, then flip toggle 0->1 before edge 1 -> word_valid high only in the cycle after edge 3; led=4'b1010 from edge 4; cmd_count=1.
- Blink (BLINK_DIV=4): word mode=01, mask=4'hF -> led=4'h0 for 4 cycles, then 4'hF for 4, repeating. A re-capture mid-period restarts the pattern lit.
- PWM dim: mode=10, duty=4, mask=4'h1 -> led[0]=0 for exactly 4 of every 16 cycles; led[3:1]=3'b111 throughout. duty=0 -> led[0] stays 1.
- Wrap/rate: 256 flips spaced SYNC_STAGES+3 apart -> 256 word_valid pulses, cmd_count ends at 0. Two flips 1 cycle apart -> at most one extra capture, no X on outputs.
- Reset with toggle=1: assert rst_n=0 mid-blink with jtag_toggle=1 and jtag_word=10'h00F, then release -> led=4'hF until edge SYNC_STAGES+2 after release, then 4'h0; cmd_count=1.
